// File: rtl/ram_port_arbiter.sv
// Two-port valid/ready arbiter in front of a single-port synchronous RAM (read-before-write).
// Define RAMARB_ROUND_ROBIN_EN for round-robin arbitration; the default build is fixed priority (port 0 wins).
module ram_port_arbiter #(
  parameter  int N_DATA      = 64,
  parameter  int N_DATA_BYTE = 4,
  localparam int N_ADDRBIT   = $clog2(N_DATA),
  localparam int N_DW        = N_DATA_BYTE * 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [1:0]               i_req_valid,
  output logic [1:0]               o_req_ready,
  input  logic [2*N_ADDRBIT-1:0]   i_req_addr,
  input  logic [2*N_DATA_BYTE-1:0] i_req_wen,
  input  logic [2*N_DW-1:0]        i_req_wdata,
  output logic [1:0]               o_rsp_valid,
  input  logic [1:0]               i_rsp_ready,
  output logic [N_DW-1:0]          o_rsp_rdata,
  output logic                     o_ram_en,
  output logic [N_ADDRBIT-1:0]     o_ram_addr,
  output logic [N_DATA_BYTE-1:0]   o_ram_wen,
  output logic [N_DW-1:0]          o_ram_wdata,
  input  logic [N_DW-1:0]          i_ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

  state_t     state_r;
  logic       owner_r;
  logic [1:0] rsp_valid_r;
  logic       rsp_accept_s;
  logic       can_grant_s;
  logic       grant_s;
  logic       gnt_port_s;
`ifdef RAMARB_ROUND_ROBIN_EN
  logic       last_r;
`endif

  // A stalled response blocks new grants so the RAM output register stays untouched.
  assign rsp_accept_s = |(rsp_valid_r & i_rsp_ready);
  assign can_grant_s  = (state_r == ST_IDLE) | rsp_accept_s;
  assign grant_s      = i_reset_n & can_grant_s & (|i_req_valid);

  // Arbitration: choose which valid port would be granted this cycle.
  always_comb begin
    gnt_port_s = 1'b0;
`ifdef RAMARB_ROUND_ROBIN_EN
    if (i_req_valid == 2'b11) begin
      gnt_port_s = ~last_r;
    end else if (i_req_valid[0]) begin
      gnt_port_s = 1'b0;
    end else begin
      gnt_port_s = 1'b1;
    end
`else
    if (i_req_valid[0]) begin
      gnt_port_s = 1'b0;
    end else begin
      gnt_port_s = 1'b1;
    end
`endif
  end

  // RAM port and request-ready steering from the granted port.
  always_comb begin
    o_req_ready = 2'b00;
    o_ram_en    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wen   = '0;
    o_ram_wdata = '0;
    if (grant_s) begin
      o_ram_en = 1'b1;
      if (gnt_port_s) begin
        o_req_ready = 2'b10;
        o_ram_addr  = i_req_addr[N_ADDRBIT +: N_ADDRBIT];
        o_ram_wen   = i_req_wen[N_DATA_BYTE +: N_DATA_BYTE];
        o_ram_wdata = i_req_wdata[N_DW +: N_DW];
      end else begin
        o_req_ready = 2'b01;
        o_ram_addr  = i_req_addr[0 +: N_ADDRBIT];
        o_ram_wen   = i_req_wen[0 +: N_DATA_BYTE];
        o_ram_wdata = i_req_wdata[0 +: N_DW];
      end
    end else begin
      o_req_ready = 2'b00;
      o_ram_en    = 1'b0;
    end
  end

  // Response FSM: tracks the owner of the outstanding RAM read result.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      rsp_valid_r <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r     <= ST_RSP;
            owner_r     <= gnt_port_s;
            rsp_valid_r <= gnt_port_s ? 2'b10 : 2'b01;
          end else begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 2'b00;
          end
        end
        ST_RSP: begin
          if (grant_s) begin
            state_r     <= ST_RSP;
            owner_r     <= gnt_port_s;
            rsp_valid_r <= gnt_port_s ? 2'b10 : 2'b01;
          end else if (rsp_accept_s) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 2'b00;
          end else begin
            state_r     <= ST_RSP;
            rsp_valid_r <= rsp_valid_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          owner_r     <= 1'b0;
          rsp_valid_r <= 2'b00;
        end
      endcase
    end
  end

`ifdef RAMARB_ROUND_ROBIN_EN
  // Remember the last granted port; reset value 1 lets port 0 win first.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      last_r <= 1'b1;
    end else if (grant_s) begin
      last_r <= gnt_port_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_rdata = i_ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural read-before-write RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_addr;
  logic [7:0]  req_wen;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic [5:0]  ram_addr;
  logic [3:0]  ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.N_DATA(64), .N_DATA_BYTE(4)) dut (
    .i_clock(clk), .i_reset_n(reset_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_ram_en(ram_en), .o_ram_addr(ram_addr), .o_ram_wen(ram_wen),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // Single-port RAM: registered read of the old word, byte writes, output held when disabled.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  task automatic clear_req();
    req_valid = 2'b00;
    req_addr  = 12'h0;
    req_wen   = 8'h0;
    req_wdata = 64'h0;
  endtask

  task automatic set_req(input int p, input logic [5:0] a, input logic [3:0] w, input logic [31:0] d);
    req_valid[p]         = 1'b1;
    req_addr[p*6 +: 6]   = a;
    req_wen[p*4 +: 4]    = w;
    req_wdata[p*32 +: 32] = d;
  endtask

  // One request with immediate response acceptance; returns what was observed.
  task automatic xact(input int p, input logic [5:0] a, input logic [3:0] w, input logic [31:0] d,
                      output logic [1:0] rdy, output logic [1:0] rv, output logic [31:0] rd);
    @(negedge clk);
    clear_req();
    set_req(p, a, w, d);
    rsp_ready = 2'b11;
    #1 rdy = req_ready;
    @(negedge clk);
    clear_req();
    #1 rv = rsp_valid;
    rd = rsp_rdata;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_req();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_req();
    rsp_ready = 2'b00;
    reset_n   = 1'b0;
    set_req(0, 6'd1, 4'hF, 32'h1);
    set_req(1, 6'd2, 4'hF, 32'h2);
    @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_cmp++; if (ram_en !== 1'b0 || ram_wen !== 4'h0) begin n_err++; $display("FAIL reset_ram_en: got en=%b wen=%h expected 0/0", ram_en, ram_wen); end
    @(negedge clk);
    clear_req();
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [1:0] rdy, rv; logic [31:0] rd;
    xact(0, 6'd5, 4'hF, 32'hDEADBEEF, rdy, rv, rd);
    n_cmp++; if (rdy !== 2'b01) begin n_err++; $display("FAIL wr_req_ready: got %b expected 01", rdy); end
    n_cmp++; if (rv !== 2'b01) begin n_err++; $display("FAIL wr_rsp_valid: got %b expected 01", rv); end
    xact(1, 6'd5, 4'h0, 32'h0, rdy, rv, rd);
    n_cmp++; if (rdy !== 2'b10) begin n_err++; $display("FAIL rd_req_ready: got %b expected 10", rdy); end
    n_cmp++; if (rv !== 2'b10) begin n_err++; $display("FAIL rd_rsp_valid: got %b expected 10", rv); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_partial_write();
    logic [1:0] rdy, rv; logic [31:0] rd;
    xact(0, 6'd3, 4'hF, 32'h11223344, rdy, rv, rd);
    xact(1, 6'd3, 4'b0010, 32'h0000AA00, rdy, rv, rd);
    n_cmp++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL pw_prewrite_data: got %h expected 11223344", rd); end
    xact(0, 6'd3, 4'h0, 32'h0, rdy, rv, rd);
    n_cmp++; if (rd !== 32'h1122AA44) begin n_err++; $display("FAIL pw_merged_data: got %h expected 1122aa44", rd); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] rdy, rv; logic [31:0] rd;
    for (int i = 0; i < 4; i++) xact(0, 6'(i), 4'hF, 32'h10000000 + 32'(i), rdy, rv, rd);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clear_req();
      set_req(0, 6'(k), 4'h0, 32'h0);
      rsp_ready = 2'b11;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 01", k, req_ready); end
      if (k > 0) begin
        n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h10000000 + 32'(k - 1)) begin
          n_err++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h expected v=01 d=%h", k - 1, rsp_valid, rsp_rdata, 32'h10000000 + 32'(k - 1));
        end
      end
    end
    @(negedge clk);
    clear_req();
    #1;
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h10000003) begin
      n_err++; $display("FAIL b2b_rsp[3]: got v=%b d=%h expected v=01 d=10000003", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] rdy, rv; logic [31:0] rd;
    xact(0, 6'd7, 4'hF, 32'hCAFE0001, rdy, rv, rd);
    @(negedge clk);
    clear_req();
    set_req(1, 6'd7, 4'h0, 32'h0);
    rsp_ready = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_grant1: got %b expected 10", req_ready); end
    @(negedge clk);
    clear_req();
    set_req(0, 6'd0, 4'h0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      #1;
      n_cmp++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hCAFE0001) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=10 d=cafe0001", s, rsp_valid, rsp_rdata);
      end
      n_cmp++; if (ram_en !== 1'b0 || req_ready !== 2'b00) begin
        n_err++; $display("FAIL bp_stall[%0d]: got en=%b ready=%b expected 0/00", s, ram_en, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01 || ram_en !== 1'b1 || rsp_rdata !== 32'hCAFE0001) begin
      n_err++; $display("FAIL bp_release: got ready=%b en=%b d=%h expected 01/1/cafe0001", req_ready, ram_en, rsp_rdata);
    end
    @(negedge clk);
    clear_req();
    #1;
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h10000000) begin
      n_err++; $display("FAIL bp_next_rsp: got v=%b d=%h expected v=01 d=10000000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [0:3];
    logic [31:0] exp_d [0:3];
    for (int k = 0; k < 4; k++) begin
`ifdef RAMARB_ROUND_ROBIN_EN
      exp_g[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g[k] = 2'b01;
`endif
      exp_d[k] = (exp_g[k] == 2'b01) ? 32'h10000000 : 32'h10000001;
    end
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clear_req();
      set_req(0, 6'd0, 4'h0, 32'h0);
      set_req(1, 6'd1, 4'h0, 32'h0);
      rsp_ready = 2'b11;
      #1;
      n_cmp++; if (req_ready !== exp_g[k]) begin n_err++; $display("FAIL cont_grant[%0d]: got %b expected %b", k, req_ready, exp_g[k]); end
      if (k > 0) begin
        n_cmp++; if (rsp_valid !== exp_g[k-1] || rsp_rdata !== exp_d[k-1]) begin
          n_err++; $display("FAIL cont_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", k - 1, rsp_valid, rsp_rdata, exp_g[k-1], exp_d[k-1]);
        end
      end
    end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    clear_req();
    set_req(0, 6'd5, 4'h0, 32'h0);
    rsp_ready = 2'b00;
    @(negedge clk);
    clear_req();
    #1;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL mr_pending: got %b expected 01", rsp_valid); end
    reset_n = 1'b0;
    set_req(0, 6'd1, 4'h0, 32'h0);
    set_req(1, 6'd2, 4'h0, 32'h0);
    #1;
    n_cmp++; if (req_ready !== 2'b00 || ram_en !== 1'b0) begin
      n_err++; $display("FAIL mr_in_reset: got ready=%b en=%b expected 00/0", req_ready, ram_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_req();
    #1;
    n_cmp++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || ram_en !== 1'b0) begin
      n_err++; $display("FAIL mr_after: got v=%b ready=%b en=%b expected 00/00/0", rsp_valid, req_ready, ram_en);
    end
    set_req(0, 6'd1, 4'h0, 32'h0);
    set_req(1, 6'd2, 4'h0, 32'h0);
    rsp_ready = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mr_first_grant: got %b expected 01", req_ready); end
    @(negedge clk);
    clear_req();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_backpressure();
    test_contention();
    test_mid_reset();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle registered read, byte write enables, read data held while the RAM enable is low) between two requesters, port 0 and port 1.
- Each port has a valid/ready request channel and a valid/ready response channel.
- The block grants at most one request per cycle and drives the RAM port.
- It returns the RAM read data to the granted port. The response is held until that port accepts it.

Parameters:
- N_DATA, 64, RAM depth in words; N_ADDRBIT = $clog2(N_DATA) is a localparam.
- N_DATA_BYTE, 4, bytes per word; data width is N_DATA_BYTE*8.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_req_valid  in  2  request valid, bit p = port p.
- o_req_ready  out  2  request accepted, bit p = port p.
- i_req_addr  in  2*N_ADDRBIT  word address; port p in slice [p*N_ADDRBIT +: N_ADDRBIT].
- i_req_wen  in  2*N_DATA_BYTE  byte write enables; all zero = read.
- i_req_wdata  in  2*N_DATA_BYTE*8  write data.
- o_rsp_valid  out  2  response valid, bit p = port p.
- i_rsp_ready  in  2  response accepted, bit p = port p.
- o_rsp_rdata  out  N_DATA_BYTE*8  response data, shared by both ports; qualified by o_rsp_valid.
- o_ram_en  out  1  RAM enable.
- o_ram_addr  out  N_ADDRBIT  RAM address.
- o_ram_wen  out  N_DATA_BYTE  RAM byte write enables.
- o_ram_wdata  out  N_DATA_BYTE*8  RAM write data.
- i_ram_rdata  in  N_DATA_BYTE*8  RAM read data.

Behaviour:
- Reset: synchronous on i_reset_n=0, sampled at the clock edge. The following values are forced:
  - State = IDLE; r_owner = 0; r_last = 1, so port 0 wins first under round-robin.
  - o_rsp_valid = 0; o_req_ready = 0; o_ram_en = 0.
- Reset mid-operation: any pending response is dropped without handshake. The RAM contents are not touched.
- The RAM control outputs are combinational from the grant. The grant drives o_ram_en/o_ram_addr/o_ram_wen/o_ram_wdata from the granted port.
- If nothing is granted, o_ram_en=0 and o_ram_wen=0.
- Grant rule: a grant is allowed when state=IDLE, or state=RSP with the current response accepted this cycle (o_rsp_valid[r_owner] & i_rsp_ready[r_owner]).
- The granted port is chosen from i_req_valid by the arbitration policy. Its o_req_ready bit is 1; the other bit is 0. o_req_ready never asserts outside a grant cycle.
- Every accepted request produces exactly one response, one cycle later:
  - Read: response data = word at addr.
  - Write: response data = pre-write word content (the RAM reads before it writes); this serves as the write acknowledge.
- Latency: request accepted in cycle N -> o_rsp_valid[p]=1 in cycle N+1.
- Throughput: one request per cycle when responses are accepted immediately.
- FSM:
  - IDLE: on grant -> RSP with r_owner = granted port; otherwise stay IDLE.
  - RSP: o_rsp_valid[r_owner]=1 and o_rsp_rdata=i_ram_rdata.
    - Response accepted and new grant -> stay RSP, r_owner updated.
    - Response accepted and no grant -> IDLE.
    - Response not accepted -> stay RSP. o_ram_en=0 and no grant, so the RAM output is held stable.
- Only one o_rsp_valid bit is ever 1. o_rsp_rdata is stable while o_rsp_valid is set and unaccepted.
- Requester rule: once a port asserts i_req_valid, it holds it and its payload until o_req_ready. The arbiter does not check this.
- Both ports valid with the same address, one reading and one writing: the read returns new data only if the write is granted first, in an earlier cycle.
- Addresses are used unmodified; there is no range check. When N_DATA is not a power of two, out-of-range addresses are undefined.

Optional Feature:
- Macro RAMARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - r_last records the last granted port and updates on every grant.
  - When both ports are valid, the port != r_last is granted.
- Undefined: fixed priority. Port 0 always wins when both ports are valid; r_last is unused.

Test Plan:
- After reset, write: port 0 requests addr 5, wen=4'hF, wdata=32'hDEADBEEF. Expect:
  - o_req_ready[0]=1 in the same cycle.
  - o_rsp_valid[0]=1 the next cycle.
  - A subsequent port 1 read of addr 5 returns 32'hDEADBEEF.
- Partial write: write addr 3 with 32'h11223344, then port 1 write wen=4'b0010, wdata=32'h0000AA00; a read of addr 3 returns 32'h1122AA44.
- Back-to-back reads: port 0 issues reads of addrs 0,1,2,3 with i_rsp_ready held 1. Expect four grants in four consecutive cycles and four responses in order, each one cycle late.
- Backpressure: port 1 read of addr 7 (content 32'hCAFE0001) with i_rsp_ready[1]=0 for 3 cycles while port 0 is valid. Expect:
  - o_rsp_rdata stays 32'hCAFE0001.
  - o_ram_en=0 and o_req_ready=2'b00 during the stall.
  - Port 0 is granted in the cycle i_rsp_ready[1] rises.
- Contention, both ports continuously valid:
  - With RAMARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1 starting at port 0.
  - Without it, port 0 is granted every cycle and port 1 is never granted.
- Mid-response reset: i_reset_n=0 while o_rsp_valid[0]=1 unaccepted. Next cycle all outputs are at reset values, state IDLE, and the first grant after reset goes to port 0.
